// File: rtl/fifo_burst_reader_pkg.sv
// ------------------------------------------------------------
// fifo_burst_reader_pkg: shared state encodings for the burst reader
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

package fifo_burst_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fifo_burst_reader_stream_out_reg.sv
// ------------------------------------------------------------
// stream_out_reg: registered valid/ready output slot with last flag
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

module stream_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_last_in,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_set_last,
  input  logic                  i_m_ready,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  output logic                  o_m_last,
  output logic                  o_slot_free
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data_in;
      r_valid <= 1'b1;
      r_last  <= i_last_in;
    end else if (r_valid && i_m_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_set_last) begin
      // Abort retags the held beat as the final one of the burst
      r_last  <= 1'b1;
    end
  end

  assign o_slot_free = ~r_valid | i_m_ready;
  assign o_m_data    = r_data;
  assign o_m_valid   = r_valid;
  assign o_m_last    = r_last;

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
// ------------------------------------------------------------
// fifo_burst_reader: pops a commanded burst from a level-sensitive FIFO
// into a registered valid/ready stream. Rev 1.0
// ------------------------------------------------------------
`default_nettype none

import fifo_burst_reader_pkg::*;

module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_start,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic                  i_cmd_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [LEN_WIDTH-1:0]  o_beats_left,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  output logic                  o_fifo_drop,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  output logic                  o_m_last,
  input  logic                  i_m_ready
);

  logic [1:0]           r_state;
  logic [LEN_WIDTH-1:0] r_beats;
  logic                 r_done;

  logic w_slot_free;
  logic w_m_valid;
  logic w_m_last;
  logic w_run;
  logic w_drop;
  logic w_last_in;
  logic w_pending;
  logic w_set_last;
  logic w_accept_last;

  assign w_run         = (r_state == ST_RUN);
  // Reset gates the pop so a mid-burst reset never shifts the FIFO
  assign w_drop        = ~rst & w_run & ~i_fifo_empty & w_slot_free &
                         (r_beats != '0) & ~i_cmd_abort;
  assign w_last_in     = (r_beats == LEN_WIDTH'(1));
  assign w_pending     = w_m_valid & ~i_m_ready;
  assign w_set_last    = w_run & i_cmd_abort & w_pending;
  assign w_accept_last = w_m_valid & i_m_ready & w_m_last;

  stream_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_stream_out_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_drop),
    .i_last_in   (w_last_in),
    .i_data_in   (i_fifo_data),
    .i_set_last  (w_set_last),
    .i_m_ready   (i_m_ready),
    .o_m_data    (o_m_data),
    .o_m_valid   (w_m_valid),
    .o_m_last    (w_m_last),
    .o_slot_free (w_slot_free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_beats <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_start) begin
            if (i_cmd_len != '0) begin
              r_state <= ST_RUN;
              r_beats <= i_cmd_len;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_cmd_abort) begin
            r_beats <= '0;
            if (w_pending) begin
              r_state <= ST_DRAIN;
            end else begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end
          end else if (w_drop) begin
            r_beats <= r_beats - LEN_WIDTH'(1);
            if (w_last_in) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_accept_last) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_beats_left = r_beats;
  assign o_fifo_drop  = w_drop;
  assign o_m_valid    = w_m_valid;
  assign o_m_last     = w_m_last;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
// ------------------------------------------------------------
// tb_fifo_burst_reader: bench for fifo_burst_reader with a 4-deep FIFO model
// Rev 1.0
// ------------------------------------------------------------
`default_nettype none

module tb_fifo_burst_reader;

  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_abort = 1'b0;
  logic          busy, done, fifo_drop, m_valid, m_last;
  logic [LW-1:0] beats_left;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data, m_data;
  logic          m_ready = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int drop_cnt = 0;
  int done_cnt = 0;
  int rdy_mode = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  int            hs_cyc[$];

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cmd_start  (cmd_start),
    .i_cmd_len    (cmd_len),
    .i_cmd_abort  (cmd_abort),
    .o_busy       (busy),
    .o_done       (done),
    .o_beats_left (beats_left),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_drop  (fifo_drop),
    .o_m_data     (m_data),
    .o_m_valid    (m_valid),
    .o_m_last     (m_last),
    .i_m_ready    (m_ready)
  );

  // Level-sensitive FIFO: head on data output, pop on drop, count registered
  logic [DW-1:0] fm   [0:DEPTH-1];
  logic [DW-1:0] fm_n [0:DEPTH-1];
  logic [2:0]    fcnt = '0;
  logic [2:0]    fcnt_n;
  logic [2:0]    c_after;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) fm_n[i] = fm[i];
    c_after = fcnt;
    if (fifo_drop && fcnt != 0) begin
      for (int i = 0; i < DEPTH - 1; i++) fm_n[i] = fm[i+1];
      fm_n[DEPTH-1] = '0;
      c_after = fcnt - 3'd1;
    end
    fcnt_n = c_after;
    if (push && c_after < 3'(DEPTH)) begin
      fm_n[c_after[1:0]] = push_data;
      fcnt_n = c_after + 3'd1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) fcnt <= '0;
    else begin
      fm   <= fm_n;
      fcnt <= fcnt_n;
    end
  end

  assign fifo_empty = (fcnt == 0);
  assign fifo_data  = (fcnt != 0) ? fm[0] : '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        hs_cyc.push_back(cyc);
      end
      if (fifo_drop) begin
        drop_cnt <= drop_cnt + 1;
        chk("drop_while_empty", {31'd0, fifo_empty}, 32'd0);
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom % 2);
      2:       m_ready = ~m_ready;
      default: m_ready = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; push = 1'b0;
    tick(); tick();
    rst = 1'b0;
    sb.delete(); got_d.delete(); got_l.delete(); hs_cyc.delete();
    drop_cnt = 0; done_cnt = 0;
  endtask

  task automatic push_one(input logic [DW-1:0] v);
    push = 1'b1; push_data = v; sb.push_back(v);
    tick();
    push = 1'b0;
  endtask

  task automatic start_cmd(input int len);
    cmd_start = 1'b1; cmd_len = LW'(len);
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit feed);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      if (feed && fcnt < 3'(DEPTH) && ($urandom % 2) == 1) push_one(DW'($urandom));
      else tick();
      k++;
    end
    tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Expected stream: first n entries pushed, in order, last flag on the n-th
  task automatic check_beats(input int n);
    logic [DW-1:0] e;
    chk("beat_count", got_d.size(), n);
    for (int i = 0; i < n && i < got_d.size(); i++) begin
      e = '1;
      if (sb.size() != 0) e = sb.pop_front();
      chk("beat_data", {24'd0, got_d[i]}, {24'd0, e});
      chk("beat_last", {31'd0, got_l[i]}, {31'd0, 1'(i == n - 1)});
    end
    got_d.delete(); got_l.delete(); hs_cyc.delete();
  endtask

  typedef struct {
    int          pre;
    logic [7:0]  base;
    logic [7:0]  step;
    int          len;
    int          mode;
    int          exp_left;
  } vec_t;

  vec_t vt[5];

  initial begin
    int k;
    int n;

    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int k;
    int len;
    int pre;

    vt[0] = '{3, 8'h11, 8'h11, 3, 0, 0};
    vt[1] = '{4, 8'h40, 8'h01, 2, 0, 2};
    vt[2] = '{4, 8'h80, 8'h03, 4, 1, 0};
    vt[3] = '{2, 8'hC0, 8'h05, 1, 2, 1};
    vt[4] = '{4, 8'hE0, 8'h01, 3, 2, 1};

    do_reset();
    chk("rst_busy",   {31'd0, busy},    32'd0);
    chk("rst_done",   {31'd0, done},    32'd0);
    chk("rst_valid",  {31'd0, m_valid}, 32'd0);
    chk("rst_last",   {31'd0, m_last},  32'd0);
    chk("rst_beats",  {24'd0, beats_left}, 32'd0);
    chk("rst_data",   {24'd0, m_data},  32'd0);

    // Table-driven bursts with the FIFO prefilled
    foreach (vt[v]) begin
      do_reset();
      rdy_mode = vt[v].mode;
      for (int i = 0; i < vt[v].pre; i++) push_one(vt[v].base + 8'(i) * vt[v].step);
      start_cmd(vt[v].len);
      wait_done(80, 1'b0);
      if (vt[v].mode == 0 && hs_cyc.size() == vt[v].len)
        chk("throughput", hs_cyc[vt[v].len-1] - hs_cyc[0], vt[v].len - 1);
      check_beats(vt[v].len);
      chk("fifo_left", {29'd0, fcnt}, vt[v].exp_left);
    end

    // FIFO runs dry mid-burst, then refills
    do_reset();
    rdy_mode = 0;
    push_one(8'hA1); push_one(8'hA2);
    start_cmd(4);
    repeat (10) tick();
    chk("stall_beats", got_d.size(), 2);
    chk("stall_drop",  {31'd0, fifo_drop}, 32'd0);
    chk("stall_left",  {24'd0, beats_left}, 32'd2);
    chk("stall_busy",  {31'd0, busy}, 32'd1);
    chk("stall_valid", {31'd0, m_valid}, 32'd0);
    push_one(8'hA3); push_one(8'hA4);
    wait_done(40, 1'b0);
    check_beats(4);

    // Backpressure holds the first beat stable
    do_reset();
    push_one(8'hC1); push_one(8'hC2); push_one(8'hC3);
    rdy_mode = 3; m_ready = 1'b0;
    start_cmd(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_data",  {24'd0, m_data}, 32'h0000_00C1);
      chk("bp_drops", drop_cnt, 1);
    end
    rdy_mode = 0; m_ready = 1'b1;
    wait_done(40, 1'b0);
    if (hs_cyc.size() == 2) chk("bp_resume_rate", hs_cyc[1] - hs_cyc[0], 1);
    check_beats(2);
    chk("bp_fifo_left", {29'd0, fcnt}, 32'd1);

    // Abort while the second beat is held
    do_reset();
    push_one(8'hD1); push_one(8'hD2); push_one(8'hD3); push_one(8'hD4);
    rdy_mode = 0; m_ready = 1'b1;
    start_cmd(5);
    k = 0;
    while (drop_cnt < 2 && k < 20) begin tick(); k++; end
    chk("abort_pre_drops", drop_cnt, 2);
    rdy_mode = 3; m_ready = 1'b0; cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    chk("abort_last",  {31'd0, m_last}, 32'd1);
    chk("abort_valid", {31'd0, m_valid}, 32'd1);
    chk("abort_data",  {24'd0, m_data}, 32'h0000_00D2);
    chk("abort_beats", {24'd0, beats_left}, 32'd0);
    chk("abort_busy",  {31'd0, busy}, 32'd1);
    push_one(8'hD5);
    repeat (3) tick();
    chk("abort_no_drop", drop_cnt, 2);
    rdy_mode = 0; m_ready = 1'b1;
    wait_done(20, 1'b0);
    check_beats(2);
    chk("abort_fifo_left", {29'd0, fcnt}, 32'd3);

    // Zero-length command and start while busy
    do_reset();
    push_one(8'hE1); push_one(8'hE2);
    start_cmd(0);
    chk("zl_done", {31'd0, done}, 32'd1);
    chk("zl_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("zl_done_clear", {31'd0, done}, 32'd0);
    chk("zl_done_cnt", done_cnt, 1);
    chk("zl_no_drop", drop_cnt, 0);
    rdy_mode = 3; m_ready = 1'b0;
    start_cmd(2);
    tick();
    cmd_start = 1'b1; cmd_len = 8'd5;
    tick();
    cmd_start = 1'b0;
    chk("busy_start_left", {24'd0, beats_left}, 32'd1);
    chk("busy_start_drops", drop_cnt, 1);
    rdy_mode = 0; m_ready = 1'b1;
    wait_done(20, 1'b0);
    check_beats(2);

    // Reset mid-burst with the FIFO non-empty
    do_reset();
    push_one(8'hF1); push_one(8'hF2); push_one(8'hF3); push_one(8'hF4);
    rdy_mode = 0; m_ready = 1'b1;
    start_cmd(4);
    tick();
    chk("pre_rst_drop", {31'd0, fifo_drop}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_drop_gate", {31'd0, fifo_drop}, 32'd0);
    tick();
    chk("mid_rst_busy",  {31'd0, busy},    32'd0);
    chk("mid_rst_done",  {31'd0, done},    32'd0);
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_last",  {31'd0, m_last},  32'd0);
    chk("mid_rst_beats", {24'd0, beats_left}, 32'd0);
    chk("mid_rst_data",  {24'd0, m_data},  32'd0);
    chk("mid_rst_drop",  {31'd0, fifo_drop}, 32'd0);

    // Random bursts with random backpressure and a live producer
    for (int it = 0; it < 20; it++) begin
      do_reset();
      rdy_mode = 1;
      pre = int'($urandom % 5);
      for (int i = 0; i < pre; i++) push_one(DW'($urandom));
      len = 1 + int'($urandom % 8);
      start_cmd(len);
      wait_done(300, 1'b1);
      check_beats(len);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
